// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: subtractor FSM states, default width and the
// validity-flag polarity used by both the adder and the serial subtractor.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic FLAG_OK  = 1'b1;
    localparam logic FLAG_OVF = 1'b0;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

    // Signed overflow shows up as disagreement between carry-in and carry-out of the MSB.
    function automatic logic msb_flag(input logic i_cin_msb, input logic i_cout_msb);
        return (i_cin_msb ^ i_cout_msb) ? FLAG_OVF : FLAG_OK;
    endfunction

endpackage

// File: rtl/somador_bit.sv
// Combinational 1-bit full adder.
module somador_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial signed subtractor, s = a - b, LSB first, one bit per clock.
// Subtraction is a + ~b + 1: the inverted subtrahend is latched and carry starts at 1.
module subtrator_serial
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             flag
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sub_state_t       r_state;
    sub_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_flag;

    logic             w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt;

    somador_bit u_fa (
        .x    (r_opa[0]),
        .y    (r_opb[0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept = start;
                if (start) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_last = (r_cnt == LAST_CNT);
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                w_accept    = start;
                w_state_nxt = start ? SHIFT : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_flag  <= FLAG_OK;
        end else begin
            if (w_accept) begin
                r_opa   <= a;
                r_opb   <= ~b;
                r_carry <= 1'b1;
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
                r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
                r_acc   <= w_acc_nxt;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            // On the final bit r_carry is the carry into the MSB, w_cout the carry out.
            if (w_last) begin
                r_s    <= w_acc_nxt;
                r_flag <= msb_flag(r_carry, w_cout);
            end
        end
    end

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign s    = r_s;
    assign flag = r_flag;

endmodule

// File: tb/tb_subtrator_serial.sv
// Scoreboard bench for subtrator_serial: stimulus pushes expected results from an
// integer reference model, a negedge monitor pops and compares on every done.
module tb_subtrator_serial;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         f;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         flag;

    int checks = 0;
    int failures = 0;

    exp_t         sb[$];
    logic [W-1:0] last_s = '0;
    logic         last_f = 1'b1;

    subtrator_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .flag  (flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer difference, wrapped for s, range-tested for flag.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib);
        exp_t e;
        int d;
        d   = int'($signed(ia)) - int'($signed(ib));
        e.a = ia;
        e.b = ib;
        e.s = W'(d);
        e.f = (d >= -(2 ** (W - 1))) && (d <= (2 ** (W - 1)) - 1);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) chk("busy_and_done", 1, 0);
            if (busy) begin
                chk("s_hold", 32'(s), 32'(last_s));
                chk("flag_hold", 32'(flag), 32'(last_f));
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("s a=%02h b=%02h", e.a, e.b), 32'(s), 32'(e.s));
                    chk($sformatf("flag a=%02h b=%02h", e.a, e.b), 32'(flag), 32'(e.f));
                    last_s = e.s;
                    last_f = e.f;
                end
            end
        end
    end

    // Caller is at a negedge with the DUT in IDLE or DONE; returns at the negedge of done.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit hold);
        int n;
        int busy_cycles;
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        sb.push_back(model(ia, ib));
        #1;
        start = hold;
        a     = W'($urandom);
        b     = W'($urandom);
        n           = 0;
        busy_cycles = 0;
        while (n < W + 4) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cycles++;
            if (hold) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            n++;
        end
        chk("done_timeout", 32'(done), 1);
        chk("busy_cycles", 32'(busy_cycles), W);
    endtask

    initial begin
        logic [W-1:0] corners[5];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_s", 32'(s), 0);
        chk("rst_flag", 32'(flag), 1);
        @(negedge clk);

        do_op(8'd5, 8'd3, 0);
        @(negedge clk);
        chk("idle_after_done", 32'(busy | done), 0);
        do_op(8'h80, 8'h01, 0);
        do_op(8'h7F, 8'hFF, 0);
        do_op(8'hFF, 8'h80, 0);
        do_op(8'h80, 8'h80, 0);
        do_op(8'h00, 8'h80, 0);

        // start held through SHIFT, then back-to-back accept in the DONE cycle
        do_op(8'h33, 8'h44, 1);
        do_op(8'd10, 8'd20, 0);
        start = 1'b0;
        @(negedge clk);

        // asynchronous abort in the middle of SHIFT
        a     = 8'h55;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_s", 32'(s), 0);
        chk("abort_flag", 32'(flag), 1);
        last_s = '0;
        last_f = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        do_op(8'd1, 8'd1, 0);

        foreach (corners[i])
            foreach (corners[j])
                do_op(corners[i], corners[j], 0);

        for (int k = 0; k < 4000; k++) begin
            do_op(W'($urandom), W'($urandom), 0);
            if ($urandom_range(0, 15) == 0) begin
                start = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
